// File: rtl/fir_sequencer_if.sv
// FIR sequencer bus: request/flag inputs and datapath control outputs.
// master = sequencer side, slave = datapath/requester side.
interface fir_sequencer_if;
  logic       dr;
  logic       lc;
  logic       overflow;
  logic       cnt_up;
  logic       clear;
  logic       modwait;
  logic [2:0] op;
  logic [3:0] src1;
  logic [3:0] src2;
  logic [3:0] dest;
  logic       err;

  modport master (
    input  dr, lc, overflow,
    output cnt_up, clear, modwait, op, src1, src2, dest, err
  );

  modport slave (
    output dr, lc, overflow,
    input  cnt_up, clear, modwait, op, src1, src2, dest, err
  );
endinterface

// File: rtl/fir_sequencer.sv
// 4-tap FIR control FSM: sequences LOAD/COPY/MUL/ADD/SUB ops on a register file.
// Ports: clk, reset (async, active-high), bus (dr/lc/overflow in; op/src/dest/flags out).
module fir_sequencer (
  input logic            clk,
  input logic            reset,
  fir_sequencer_if.master bus
);

  localparam logic [4:0] IDLE   = 5'd0;
  localparam logic [4:0] STORE  = 5'd1;
  localparam logic [4:0] ZERO   = 5'd2;
  localparam logic [4:0] SORT1  = 5'd3;
  localparam logic [4:0] SORT2  = 5'd4;
  localparam logic [4:0] SORT3  = 5'd5;
  localparam logic [4:0] SORT4  = 5'd6;
  localparam logic [4:0] MUL1   = 5'd7;
  localparam logic [4:0] ADD1   = 5'd8;
  localparam logic [4:0] MUL2   = 5'd9;
  localparam logic [4:0] SUB2   = 5'd10;
  localparam logic [4:0] MUL3   = 5'd11;
  localparam logic [4:0] ADD3   = 5'd12;
  localparam logic [4:0] MUL4   = 5'd13;
  localparam logic [4:0] SUB4   = 5'd14;
  localparam logic [4:0] EIDLE  = 5'd15;
  localparam logic [4:0] LOADC0 = 5'd16;
  localparam logic [4:0] LOADC1 = 5'd17;
  localparam logic [4:0] LOADC2 = 5'd18;
  localparam logic [4:0] LOADC3 = 5'd19;
  localparam logic [4:0] WAITC0 = 5'd20;
  localparam logic [4:0] WAITC1 = 5'd21;
  localparam logic [4:0] WAITC2 = 5'd22;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_COPY  = 3'd1;
  localparam logic [2:0] OP_LOAD1 = 3'd2;
  localparam logic [2:0] OP_LOAD2 = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  logic [4:0] state;
  logic [4:0] next_state;
  logic       busy;
  logic       busy_next;

  logic [2:0] op;
  logic [3:0] src1;
  logic [3:0] src2;
  logic [3:0] dest;
  logic       cnt_up;
  logic       clear;
  logic       err;

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (bus.dr)      next_state = STORE;
        else if (bus.lc) next_state = LOADC0;
        else             next_state = IDLE;
      end
      STORE:  next_state = bus.dr ? ZERO : EIDLE;
      ZERO:   next_state = SORT1;
      SORT1:  next_state = SORT2;
      SORT2:  next_state = SORT3;
      SORT3:  next_state = SORT4;
      SORT4:  next_state = MUL1;
      MUL1:   next_state = ADD1;
      ADD1:   next_state = bus.overflow ? EIDLE : MUL2;
      MUL2:   next_state = SUB2;
      SUB2:   next_state = bus.overflow ? EIDLE : MUL3;
      MUL3:   next_state = ADD3;
      ADD3:   next_state = bus.overflow ? EIDLE : MUL4;
      MUL4:   next_state = SUB4;
      SUB4:   next_state = bus.overflow ? EIDLE : IDLE;
      EIDLE: begin
        if (bus.dr)      next_state = STORE;
        else if (bus.lc) next_state = LOADC0;
        else             next_state = EIDLE;
      end
      LOADC0: next_state = WAITC0;
      LOADC1: next_state = WAITC1;
      LOADC2: next_state = WAITC2;
      LOADC3: next_state = IDLE;
      WAITC0: next_state = bus.lc ? LOADC1 : WAITC0;
      WAITC1: next_state = bus.lc ? LOADC2 : WAITC1;
      WAITC2: next_state = bus.lc ? LOADC3 : WAITC2;
      default: next_state = IDLE;
    endcase
  end

  // Busy is registered from next_state so it tracks the state register.
  assign busy_next = !((next_state == IDLE) ||
                       (next_state == EIDLE) ||
                       (next_state == WAITC0) ||
                       (next_state == WAITC1) ||
                       (next_state == WAITC2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_next;
    end
  end

  always_comb begin
    op     = OP_NOP;
    src1   = 4'd0;
    src2   = 4'd0;
    dest   = 4'd0;
    cnt_up = 1'b0;
    clear  = 1'b0;
    err    = 1'b0;
    case (state)
      STORE:  begin op = OP_LOAD1; dest = 4'd5; end
      ZERO:   begin op = OP_SUB; cnt_up = 1'b1; end
      SORT1:  begin op = OP_COPY; src1 = 4'd2; dest = 4'd1; end
      SORT2:  begin op = OP_COPY; src1 = 4'd3; dest = 4'd2; end
      SORT3:  begin op = OP_COPY; src1 = 4'd4; dest = 4'd3; end
      SORT4:  begin op = OP_COPY; src1 = 4'd5; dest = 4'd4; end
      MUL1:   begin op = OP_MUL; src1 = 4'd1; src2 = 4'd6; dest = 4'd5; end
      ADD1:   begin op = OP_ADD; src2 = 4'd5; end
      MUL2:   begin op = OP_MUL; src1 = 4'd2; src2 = 4'd7; dest = 4'd5; end
      SUB2:   begin op = OP_SUB; src2 = 4'd5; end
      MUL3:   begin op = OP_MUL; src1 = 4'd3; src2 = 4'd8; dest = 4'd5; end
      ADD3:   begin op = OP_ADD; src2 = 4'd5; end
      MUL4:   begin op = OP_MUL; src1 = 4'd4; src2 = 4'd9; dest = 4'd5; end
      SUB4:   begin op = OP_SUB; src2 = 4'd5; end
      EIDLE:  err = 1'b1;
      LOADC0: begin op = OP_LOAD2; dest = 4'd6; clear = 1'b1; end
      LOADC1: begin op = OP_LOAD2; dest = 4'd7; end
      LOADC2: begin op = OP_LOAD2; dest = 4'd8; end
      LOADC3: begin op = OP_LOAD2; dest = 4'd9; end
      default: ;
    endcase
  end

  assign bus.op      = op;
  assign bus.src1    = src1;
  assign bus.src2    = src2;
  assign bus.dest    = dest;
  assign bus.cnt_up  = cnt_up;
  assign bus.clear   = clear;
  assign bus.err     = err;
  assign bus.modwait = busy;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: sample run, coeff load, error paths, reset.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_fir_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fir_sequencer_if bus();

  fir_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived op/src1/src2/dest per cycle of a full sample run.
  int exp_op   [0:13] = '{2, 5, 1, 1, 1, 1, 6, 4, 6, 5, 6, 4, 6, 5};
  int exp_src1 [0:13] = '{0, 0, 2, 3, 4, 5, 1, 0, 2, 0, 3, 0, 4, 0};
  int exp_src2 [0:13] = '{0, 0, 0, 0, 0, 0, 6, 5, 7, 5, 8, 5, 9, 5};
  int exp_dest [0:13] = '{5, 0, 1, 2, 3, 4, 5, 0, 5, 0, 5, 0, 5, 0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.dr = 1'b0;
    bus.lc = 1'b0;
    bus.overflow = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.dr = 1'b1;
    bus.lc = 1'b1;
    bus.overflow = 1'b0;
    step();
    step();
    checks++;
    if ({bus.op, bus.src1, bus.src2, bus.dest} !== 15'd0) begin
      failures++;
      $display("FAIL reset_fields got=%h want=0",
               {bus.op, bus.src1, bus.src2, bus.dest});
    end
    checks++;
    if ({bus.modwait, bus.cnt_up, bus.clear, bus.err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000",
               {bus.modwait, bus.cnt_up, bus.clear, bus.err});
    end
    bus.dr = 1'b0;
    bus.lc = 1'b0;
    reset = 1'b0;
    step();
    checks++;
    if ({bus.op, bus.modwait} !== 4'd0) begin
      failures++;
      $display("FAIL reset_release_idle op=%0d mw=%b want 0/0",
               bus.op, bus.modwait);
    end
  endtask

  task automatic test_sample_run();
    logic [2:0] o_op [0:15];
    logic [3:0] o_s1 [0:15];
    logic [3:0] o_s2 [0:15];
    logic [3:0] o_d  [0:15];
    logic       o_mw [0:15];
    logic       o_cu [0:15];
    int mw_cnt;
    int cu_cnt;
    do_reset();
    bus.dr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      o_op[i] = bus.op;
      o_s1[i] = bus.src1;
      o_s2[i] = bus.src2;
      o_d[i]  = bus.dest;
      o_mw[i] = bus.modwait;
      o_cu[i] = bus.cnt_up;
      if (i == 1) bus.dr = 1'b0;
    end
    mw_cnt = 0;
    cu_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (o_mw[i]) mw_cnt++;
      if (o_cu[i]) cu_cnt++;
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (o_op[i] !== exp_op[i][2:0] || o_s1[i] !== exp_src1[i][3:0] ||
          o_s2[i] !== exp_src2[i][3:0] || o_d[i] !== exp_dest[i][3:0]) begin
        failures++;
        $display("FAIL sample_cycle%0d got op=%0d s1=%0d s2=%0d d=%0d want op=%0d s1=%0d s2=%0d d=%0d",
                 i, o_op[i], o_s1[i], o_s2[i], o_d[i],
                 exp_op[i], exp_src1[i], exp_src2[i], exp_dest[i]);
      end
    end
    checks++;
    if (mw_cnt != 14 || o_mw[13] !== 1'b1 || o_mw[14] !== 1'b0) begin
      failures++;
      $display("FAIL sample_modwait count=%0d want 14", mw_cnt);
    end
    checks++;
    if (cu_cnt != 1 || o_cu[1] !== 1'b1) begin
      failures++;
      $display("FAIL sample_cnt_up count=%0d want 1 at ZERO", cu_cnt);
    end
    checks++;
    if (o_op[14] !== 3'd0 || o_op[15] !== 3'd0) begin
      failures++;
      $display("FAIL sample_idle_after op=%0d want 0", o_op[14]);
    end
  endtask

  task automatic test_coeff_load();
    int clr_cnt;
    do_reset();
    clr_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      bus.lc = 1'b1;
      step();
      bus.lc = 1'b0;
      if (bus.clear) clr_cnt++;
      checks++;
      if (bus.op !== 3'd3 || bus.dest !== 4'(6 + n) || bus.modwait !== 1'b1) begin
        failures++;
        $display("FAIL coeff_load%0d got op=%0d d=%0d mw=%b want op=3 d=%0d mw=1",
                 n, bus.op, bus.dest, bus.modwait, 6 + n);
      end
      if (n < 3) begin
        bus.dr = (n == 1);
        step();
        step();
        bus.dr = 1'b0;
        if (bus.clear) clr_cnt++;
        checks++;
        if (bus.op !== 3'd0 || bus.modwait !== 1'b0) begin
          failures++;
          $display("FAIL coeff_wait%0d got op=%0d mw=%b want op=0 mw=0",
                   n, bus.op, bus.modwait);
        end
      end
    end
    step();
    checks++;
    if (bus.op !== 3'd0 || bus.modwait !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL coeff_done got op=%0d mw=%b err=%b want idle",
               bus.op, bus.modwait, bus.err);
    end
    checks++;
    if (clr_cnt != 1) begin
      failures++;
      $display("FAIL coeff_clear_count got=%0d want=1", clr_cnt);
    end
  endtask

  task automatic test_premature_dr();
    int mw_cnt;
    do_reset();
    bus.dr = 1'b1;
    step();
    bus.dr = 1'b0;
    step();
    checks++;
    if (bus.err !== 1'b1 || bus.modwait !== 1'b0 || bus.op !== 3'd0) begin
      failures++;
      $display("FAIL premature_eidle got err=%b mw=%b op=%0d want 1/0/0",
               bus.err, bus.modwait, bus.op);
    end
    step();
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL premature_hold err=%b want 1", bus.err);
    end
    bus.dr = 1'b1;
    step();
    checks++;
    if (bus.err !== 1'b0 || bus.op !== 3'd2 || bus.modwait !== 1'b1) begin
      failures++;
      $display("FAIL premature_restart got err=%b op=%0d mw=%b want 0/2/1",
               bus.err, bus.op, bus.modwait);
    end
    mw_cnt = 1;
    step();
    bus.dr = 1'b0;
    for (int i = 0; i < 30 && bus.modwait; i++) begin
      mw_cnt++;
      step();
    end
    checks++;
    if (mw_cnt != 14 || bus.err !== 1'b0 || bus.modwait !== 1'b0) begin
      failures++;
      $display("FAIL premature_full_run mw_cycles=%0d err=%b want 14/0",
               mw_cnt, bus.err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.dr = 1'b1;
    step();
    step();
    bus.dr = 1'b0;
    repeat (10) step();
    checks++;
    if (bus.op !== 3'd4) begin
      failures++;
      $display("FAIL overflow_at_add3 op=%0d want 4", bus.op);
    end
    bus.overflow = 1'b1;
    step();
    bus.overflow = 1'b0;
    checks++;
    if (bus.err !== 1'b1 || bus.op !== 3'd0 || bus.modwait !== 1'b0) begin
      failures++;
      $display("FAIL overflow_eidle got err=%b op=%0d mw=%b want 1/0/0",
               bus.err, bus.op, bus.modwait);
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.dr = 1'b1;
    bus.lc = 1'b1;
    step();
    bus.dr = 1'b0;
    bus.lc = 1'b0;
    checks++;
    if (bus.op !== 3'd2 || bus.dest !== 4'd5 || bus.clear !== 1'b0) begin
      failures++;
      $display("FAIL priority got op=%0d d=%0d clr=%b want op=2 d=5 clr=0",
               bus.op, bus.dest, bus.clear);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.dr = 1'b1;
    step();
    step();
    bus.dr = 1'b0;
    repeat (7) step();
    checks++;
    if (bus.op !== 3'd6 || bus.src1 !== 4'd2 || bus.src2 !== 4'd7) begin
      failures++;
      $display("FAIL reset_mid_at_mul2 op=%0d s1=%0d want op=6 s1=2",
               bus.op, bus.src1);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.op !== 3'd0 || bus.modwait !== 1'b0 ||
        {bus.src1, bus.src2, bus.dest} !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid_async op=%0d mw=%b want 0/0",
               bus.op, bus.modwait);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.op !== 3'd0 || bus.modwait !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle op=%0d mw=%b want 0/0",
               bus.op, bus.modwait);
    end
    bus.dr = 1'b1;
    step();
    bus.dr = 1'b0;
    checks++;
    if (bus.op !== 3'd2 || bus.modwait !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_restart op=%0d mw=%b want 2/1",
               bus.op, bus.modwait);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.dr = 1'b0;
    bus.lc = 1'b0;
    bus.overflow = 1'b0;
    test_reset();
    test_sample_run();
    test_coeff_load();
    test_premature_dr();
    test_overflow();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port `dr`, input, 1 bit: synchronized sample-ready request from the upstream synchronizer.
REQ-005 Port `lc`, input, 1 bit: synchronized load-coefficient request.
REQ-006 Port `overflow`, input, 1 bit: datapath ALU overflow flag, valid in the cycle of the op that produced it.
REQ-007 Port `cnt_up`, output, 1 bit: single-cycle increment pulse to the sample counter.
REQ-008 Port `clear`, output, 1 bit: single-cycle clear pulse to the sample counter.
REQ-009 Port `modwait`, output, 1 bit: registered busy flag.
REQ-010 Port `op`, output, 3 bits: datapath op code. 0=NOP, 1=COPY, 2=LOAD1 (sample), 3=LOAD2 (coeff), 4=ADD, 5=SUB, 6=MUL, 7=reserved.
REQ-011 Ports `src1`, `src2`, `dest`, output, 4 bits each: register-file indices.
REQ-012 Port `err`, output, 1 bit: sticky error flag.

Function
REQ-013 The register map SHALL be: R0 = accumulator, R1..R4 = sample history with R4 newest, R5 = scratch, R6..R9 = coefficients F0..F3.
REQ-014 The FSM SHALL have these states: IDLE, STORE, ZERO, SORT1..SORT4, MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4, EIDLE, LOADC0..LOADC3, WAITC0..WAITC2.
REQ-015 Outputs `op`, `src1`, `src2`, `dest`, `cnt_up`, `clear` and `err` SHALL be Moore-decoded from the current state; fields not listed for a state are 0.
REQ-016 In IDLE, `dr`=1 SHALL go to STORE; else `lc`=1 SHALL go to LOADC0; else the FSM stays in IDLE. `dr` has priority over `lc`.
REQ-017 STORE: op=LOAD1, dest=R5. Next state is ZERO if `dr`=1, else EIDLE (premature `dr` drop).
REQ-018 ZERO: op=SUB, src1=src2=dest=R0, `cnt_up`=1.
REQ-019 SORT1..SORT4 SHALL each perform a COPY, in order: R1<-R2, R2<-R3, R3<-R4, R4<-R5.
REQ-020 For tap k=0..3, MULk+1 SHALL perform a MUL with src1=R(k+1), src2=R(6+k), dest=R5.
REQ-021 Each MUL SHALL be followed by R0<-R0 op R5, where op is ADD for taps 0 and 2 and SUB for taps 1 and 3.
REQ-022 When `overflow`=1 in any ADD or SUB state, the FSM SHALL go to EIDLE instead of continuing.
REQ-023 From SUB4 without overflow, the FSM SHALL go to IDLE.
REQ-024 Sample processing SHALL take exactly 14 cycles from the STORE entry edge to the IDLE entry edge.
REQ-025 EIDLE: op=NOP, `err`=1. `dr`=1 SHALL go to STORE, which drops `err`; `lc`=1 SHALL go to LOADC0; otherwise the FSM stays in EIDLE.
REQ-026 LOADCn: op=LOAD2, dest=R(6+n). `clear`=1 in LOADC0 only.
REQ-027 LOADC0..LOADC2 SHALL go to WAITCn.
REQ-028 LOADC3 SHALL go to IDLE.
REQ-029 WAITCn SHALL go to LOADC(n+1) when `lc`=1 and hold otherwise; `dr` is ignored in WAITCn.
REQ-030 `modwait` SHALL be registered from next-state.
REQ-031 `modwait` SHALL be 1 in every state except IDLE, EIDLE and WAITC0..WAITC2, so it rises on the same edge that enters STORE or LOADCn.
REQ-032 A `dr` or `lc` held high across an IDLE return SHALL start a new operation; the sequencer does no edge detection.
REQ-033 Reset mid-operation SHALL abort immediately, with no partial register updates issued after reset.

Reset
REQ-034 While `reset`=1, the state SHALL be IDLE, `modwait`=0, op=NOP, `src1`=`src2`=`dest`=0, and `cnt_up`=`clear`=`err`=0.
REQ-035 The first transition after `reset` falls SHALL occur on the next rising edge of `clk`.

Verification
REQ-036 Bench scenario: `dr`=1 held for 2 cycles from IDLE, no overflow. Expect `modwait` high for exactly 14 cycles, `cnt_up` high for 1 cycle (ZERO), and this op sequence: LOAD1, SUB, COPY x4, MUL, ADD, MUL, SUB, MUL, ADD, MUL, SUB.
REQ-037 Bench scenario: four `lc` pulses. Expect LOAD2 to dest 6, 7, 8, 9 in order, `clear`=1 once (LOADC0), and `modwait` low in each WAITCn.
REQ-038 Bench scenario: `dr` high for 1 cycle only. Expect STORE -> EIDLE, `err`=1, `modwait`=0; a later `dr` clears `err` and the full 14-cycle sequence completes.
REQ-039 Bench scenario: `overflow`=1 during ADD3. Expect the next state to be EIDLE with `err`=1, and no MUL4 op issued.
REQ-040 Bench scenario: `dr`=1 and `lc`=1 asserted in the same IDLE cycle. Expect STORE is entered, not LOADC0.
REQ-041 Bench scenario: `reset` asserted during MUL2. Expect within the same cycle, with no clock edge, op=NOP and `modwait`=0; IDLE resumes after release.
